// File: rtl/contador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : contador_pkg
//  Description : Shared constants for the BCD counter / 7-segment scan driver:
//                digit width, segment patterns {a,b,c,d,e,f,g} and a BCD
//                digit validity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package contador_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // A BCD digit is legal only for codes 0..9.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
    return (digit <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : Combinational BCD digit to 7-segment pattern (active high,
//                seg[6:0] = {a,b,c,d,e,f,g}); codes above 9 are blanked.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
  import contador_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [6:0]       seg
);

  // Table lookup; non-BCD codes show nothing rather than garbage.
  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/contador_bcd_display.sv
`default_nettype none
// ============================================================================
//  Module      : contador_bcd_display
//  Description : Parametrised BCD up/down counter with programmable modulo,
//                synchronous load, prescaled count tick and a multiplexed
//                7-segment scan driver. All arithmetic is done digit-wise in
//                BCD.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_bcd_display
  import contador_pkg::*;
#(
  parameter int N_DIGITS       = 2,
  parameter int MODULO         = 60,
  parameter int PRESCALE       = 50_000_000,
  parameter int SCAN_DIV       = 50_000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
)
(
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      up_down,
  input  logic                      load,
  input  logic [BCD_W*N_DIGITS-1:0] load_value,
  output logic [BCD_W*N_DIGITS-1:0] count_bcd,
  output logic                      wrap,
  output logic                      load_err,
  output logic [6:0]                seg,
  output logic [N_DIGITS-1:0]       an
);

  localparam int CW = BCD_W * N_DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  // Elaboration-time only: turns MODULO-1 into its BCD image so the runtime
  // compares and rollover values stay purely in BCD.
  function automatic logic [CW-1:0] to_bcd(input int value);
    logic [CW-1:0] r;
    int            v;
    r = '0;
    v = value;
    for (int i = 0; i < N_DIGITS; i++) begin
      r[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [CW-1:0]       MAX_BCD = to_bcd(MODULO - 1);
  localparam logic [6:0]          SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] AN_POL  = {N_DIGITS{SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] AN_ONE  = N_DIGITS'(1);

  logic [PW-1:0]    r_presc;
  logic [SW-1:0]    r_scan_div;
  logic [IW-1:0]    r_scan_idx;
  logic             w_step;
  logic             w_load_ok;
  logic [CW-1:0]    w_count_inc;
  logic [CW-1:0]    w_count_dec;
  logic [BCD_W-1:0] w_scan_digit;
  logic [6:0]       w_seg;

  assign w_step = enable && (r_presc == PRESC_LAST);

  // Load acceptance: every digit legal BCD, and value within range. With all
  // digits legal, unsigned compare of BCD vectors equals numeric compare.
  always_comb begin : p_load_check
    logic digits_ok;
    digits_ok = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!bcd_valid(load_value[i*BCD_W +: BCD_W])) digits_ok = 1'b0;
    end
    w_load_ok = digits_ok && (load_value <= MAX_BCD);
  end

  // Decimal increment with ripple carry (9 -> 0 carries into next digit).
  always_comb begin : p_inc
    logic carry;
    carry       = 1'b1;
    w_count_inc = count_bcd;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (count_bcd[i*BCD_W +: BCD_W] == 4'd9) begin
          w_count_inc[i*BCD_W +: BCD_W] = 4'd0;
        end else begin
          w_count_inc[i*BCD_W +: BCD_W] = count_bcd[i*BCD_W +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Decimal decrement with ripple borrow (0 -> 9 borrows from next digit).
  always_comb begin : p_dec
    logic borrow;
    borrow      = 1'b1;
    w_count_dec = count_bcd;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (borrow) begin
        if (count_bcd[i*BCD_W +: BCD_W] == 4'd0) begin
          w_count_dec[i*BCD_W +: BCD_W] = 4'd9;
        end else begin
          w_count_dec[i*BCD_W +: BCD_W] = count_bcd[i*BCD_W +: BCD_W] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Prescaler: runs only while enabled, restarts on an accepted load.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (load && w_load_ok) begin
      r_presc <= '0;
    end else if (enable) begin
      r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
    end
  end

  // Counter: load beats step beats hold; rejected loads also swallow a step.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_bcd <= '0;
      wrap      <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (w_load_ok) count_bcd <= load_value;
        else           load_err  <= 1'b1;
      end else if (w_step) begin
        if (up_down) begin
          if (count_bcd == MAX_BCD) begin
            count_bcd <= '0;
            wrap      <= 1'b1;
          end else begin
            count_bcd <= w_count_inc;
          end
        end else begin
          if (count_bcd == '0) begin
            count_bcd <= MAX_BCD;
            wrap      <= 1'b1;
          end else begin
            count_bcd <= w_count_dec;
          end
        end
      end
    end
  end

  // Scan divider and digit index, free running regardless of enable/load.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_div <= '0;
      r_scan_idx <= '0;
    end else if (r_scan_div == SCAN_LAST) begin
      r_scan_div <= '0;
      r_scan_idx <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + IW'(1);
    end else begin
      r_scan_div <= r_scan_div + SW'(1);
    end
  end

  // Pick the digit currently being scanned.
  always_comb begin
    w_scan_digit = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_scan_idx == IW'(i)) w_scan_digit = count_bcd[i*BCD_W +: BCD_W];
    end
  end

  seg7_decoder u_seg7_decoder (
    .digit (w_scan_digit),
    .seg   (w_seg)
  );

  // Display registers: an and seg move together so only one digit lights.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_ONE ^ AN_POL;
      seg <= SEG_0 ^ SEG_POL;
    end else begin
      an  <= (AN_ONE << r_scan_idx) ^ AN_POL;
      seg <= w_seg ^ SEG_POL;
    end
  end

endmodule
`default_nettype wire
